sub32_ser4: RTL and testbench

SUB32_SER4 -- requirements
Module: sub32_ser4

---
 rtl/sub32_ser4.sv | 123 ++++++++++++
 tb/tb_sub32_ser4.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/sub32_ser4.sv
// Serial 32-bit subtractor: computes a - b as a + ~b + 1, one 4-bit nibble per
// clock through a single add slice and a carry flop; result valid on done.
module sub32_ser4 (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] d,
  output logic        borrow,
  output logic        ovf,
  output logic        zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        carry_q, carry_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] d_q, d_d;
  logic        borrow_q, borrow_d;
  logic        ovf_q, ovf_d;
  logic        zero_q, zero_d;

  logic [3:0]  a_nib, b_nib;
  logic [4:0]  nib_sum;

  // The one shared 4-bit slice; cnt selects which nibble passes through it.
  assign a_nib   = a_q[{cnt_q, 2'b00} +: 4];
  assign b_nib   = b_q[{cnt_q, 2'b00} +: 4];
  assign nib_sum = {1'b0, a_nib} + {1'b0, ~b_nib} + {4'd0, carry_q};

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    d_d      = d_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d      = a;
          b_d      = b;
          carry_d  = 1'b1;
          cnt_d    = 3'd0;
          d_d      = 32'd0;
          borrow_d = 1'b0;
          ovf_d    = 1'b0;
          zero_d   = 1'b0;
          state_d  = RUN;
        end
      end
      RUN: begin
        d_d[{cnt_q, 2'b00} +: 4] = nib_sum[3:0];
        carry_d = nib_sum[4];
        if (cnt_q == 3'd7) begin
          // Flags use the nibble being stored now, since d_q lacks it yet.
          borrow_d = ~nib_sum[4];
          ovf_d    = (a_q[31] != b_q[31]) && (nib_sum[3] != a_q[31]);
          zero_d   = (d_q[27:0] == 28'd0) && (nib_sum[3:0] == 4'd0);
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values,
    // independent of statement order within this block.
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 3'd0;
      carry_q  <= 1'b0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      d_q      <= 32'd0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      d_q      <= d_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign d      = d_q;
  assign borrow = borrow_q;
  assign ovf    = ovf_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_sub32_ser4.sv
// Directed self-checking bench for sub32_ser4: hand-computed differences,
// latency/busy timing, back-to-back starts and mid-run reset.
module tb_sub32_ser4;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] d;
  logic        borrow;
  logic        ovf;
  logic        zero;

  int n_checks = 0;
  int n_errors = 0;

  sub32_ser4 dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .d      (d),
    .borrow (borrow),
    .ovf    (ovf),
    .zero   (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full operation: start is pulsed at the accepted edge, operands are
  // scrambled afterwards, and done must appear in the 9th cycle after it.
  task automatic run_op(input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] ed, input logic eb, input logic eo,
                        input logic ez);
    int  busy_cycles;
    bit  seen;
    busy_cycles = 0;
    seen        = 1'b0;
    @(negedge clk);
    a     = av;
    b     = bv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(negedge clk);
      if (busy) busy_cycles++;
      if (k == 1) begin
        check("run_d_cleared", d, 32'd0);
        check("run_flags_zero", {29'd0, borrow, ovf, zero}, 32'd0);
      end
      if (done) begin
        seen = 1'b1;
        check("done_latency", k, 32'd9);
        check("diff", d, ed);
        check("borrow", {31'd0, borrow}, {31'd0, eb});
        check("ovf", {31'd0, ovf}, {31'd0, eo});
        check("zero", {31'd0, zero}, {31'd0, ez});
      end
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
    check("busy_cycles", busy_cycles, 32'd9);
    @(negedge clk);
    check("idle_after_done", {30'd0, busy, done}, 32'd0);
    check("diff_hold", d, ed);
  endtask

  logic [31:0] bb_a [3];
  logic [31:0] bb_b [3];
  logic [31:0] bb_d [3];

  initial begin
    reset = 1'b1;
    start = 1'b1;
    a     = 32'hDEADBEEF;
    b     = 32'h12345678;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy_done", {30'd0, busy, done}, 32'd0);
    check("reset_d", d, 32'd0);
    check("reset_flags", {29'd0, borrow, ovf, zero}, 32'd0);
    reset = 1'b0;
    start = 1'b0;

    run_op(32'h00000005, 32'h00000003, 32'h00000002, 1'b0, 1'b0, 1'b0);
    run_op(32'h00000003, 32'h00000005, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0);
    run_op(32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0);
    run_op(32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1'b1, 1'b1, 1'b0);
    run_op(32'h12345678, 32'h12345678, 32'h00000000, 1'b0, 1'b0, 1'b1);
    run_op(32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b1);
    run_op(32'h00000010, 32'h00000001, 32'h0000000F, 1'b0, 1'b0, 1'b0);

    // Back-to-back: start held high, operands change every cycle; only the
    // values present at E0, E10 and E20 may count.
    bb_a[0] = 32'h00001000; bb_b[0] = 32'h00000001; bb_d[0] = 32'h00000FFF;
    bb_a[1] = 32'hFFFFFFFF; bb_b[1] = 32'h0000000F; bb_d[1] = 32'hFFFFFFF0;
    bb_a[2] = 32'h00000100; bb_b[2] = 32'h00000200; bb_d[2] = 32'hFFFFFF00;
    @(negedge clk);
    a     = bb_a[0];
    b     = bb_b[0];
    start = 1'b1;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk);
      #1;
      if (n == 29) begin
        start = 1'b0;
      end else if ((n + 1) % 10 == 0) begin
        a = bb_a[(n + 1) / 10];
        b = bb_b[(n + 1) / 10];
      end else begin
        a = $urandom;
        b = $urandom;
      end
      @(negedge clk);
      check("b2b_done", {31'd0, done}, {31'd0, (n % 10) == 8});
      if ((n % 10) == 8) check("b2b_diff", d, bb_d[n / 10]);
    end

    // Reset landing on the RUN edge with cnt=4 (E5) abandons the operation.
    @(negedge clk);
    a     = 32'hAAAA5555;
    b     = 32'h11112222;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("midrun_reset_busy_done", {30'd0, busy, done}, 32'd0);
    check("midrun_reset_d", d, 32'd0);
    check("midrun_reset_flags", {29'd0, borrow, ovf, zero}, 32'd0);
    begin
      int done_seen;
      done_seen = 0;
      for (int k = 0; k < 12; k++) begin
        @(negedge clk);
        if (done || busy) done_seen++;
      end
      check("no_done_after_reset", done_seen, 32'd0);
    end
    run_op(32'h0000FFFF, 32'h00000001, 32'h0000FFFE, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
